// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access runs IDLE (grant) -> ACCESS (memory strobe) -> RESP (done, load capture).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    state_t            state_q, state_d;
    txn_t              txn_q, txn_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              win;

    always_comb begin
        state_d   = state_q;
        txn_d     = txn_q;
        last_d    = last_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        // Under contention the port that did not win last time goes first.
        win = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d     = ACCESS;
                    last_d      = win;
                    txn_d.port  = win;
                    txn_d.we    = win ? we1 : we0;
                    txn_d.addr  = win ? addr1 : addr0;
                    txn_d.wdata = win ? wdata1 : wdata0;
                    // Gated so a held request cannot show a grant while reset is low.
                    gnt0        = rst & ~win;
                    gnt1        = rst & win;
                end
            end
            ACCESS: begin
                mem_wr_en = txn_q.we;
                mem_rd_en = ~txn_q.we;
                state_d   = RESP;
            end
            RESP: begin
                done0 = ~txn_q.port;
                done1 = txn_q.port;
                if (!txn_q.we) begin
                    if (txn_q.port) rdata1_d = mem_rdata;
                    else            rdata0_d = mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            txn_q    <= '0;
            last_q   <= 1'b1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            txn_q    <= txn_d;
            last_q   <= last_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_addr  = txn_q.addr;
    assign mem_wdata = txn_q.wdata;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written reset/withdraw
// sequences, then random two-port traffic against a transaction-level model.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, busy, mem_wr_en, mem_rd_en;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory standing in for data_mem, 16 words.
    logic          mem_clr = 1'b1;
    logic [DW-1:0] tmem [16];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) tmem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_wr_en) tmem[mem_addr[3:0]] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= tmem[mem_addr[3:0]];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic inv_chk();
        chk("wr_rd_both", 64'(mem_wr_en & mem_rd_en), 0);
        chk("en_when_idle", 64'((mem_wr_en | mem_rd_en) & ~busy), 0);
        chk("gnt_both", 64'(gnt0 & gnt1), 0);
        chk("done_both", 64'(done0 & done1), 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic r0, w0; logic [31:0] a0, d0;
        logic r1, w1; logic [31:0] a1, d1;
        logic g0, g1, dn0, dn1, wr, rd, bz;
        logic [31:0] rd1, ea, ed;
    } vec_t;

    function automatic vec_t mk(
        logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
        logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
        logic g0, logic g1, logic dn0, logic dn1, logic wr, logic rd, logic bz,
        logic [31:0] rd1, logic [31:0] ea, logic [31:0] ed);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.dn0 = dn0; v.dn1 = dn1;
        v.wr = wr; v.rd = rd; v.bz = bz; v.rd1 = rd1; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    vec_t vt [20];

    // Transaction-level reference model state.
    logic [31:0] ref_mem [16];
    logic [31:0] ref_rd  [2];
    logic        ref_last, cport, cwe, pend0, pend1, sg0, sg1, p;
    logic [31:0] caddr, cwd, ref_ma, ref_mwd;
    int          gcyc, cyc, off;

    initial begin
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Build the directed table: store, load-back, then 4 contended grants.
        vt[0] = mk(1,1,4,'h10, 0,0,0,0,  1,0,0,0,0,0,0, 0, 0, 0);
        vt[1] = mk(0,0,0,0,    0,0,0,0,  0,0,0,0,1,0,1, 0, 4, 'h10);
        vt[2] = mk(0,0,0,0,    0,0,0,0,  0,0,1,0,0,0,1, 0, 0, 0);
        vt[3] = mk(0,0,0,0,    1,0,4,0,  0,1,0,0,0,0,0, 0, 0, 0);
        vt[4] = mk(0,0,0,0,    0,0,0,0,  0,0,0,0,0,1,1, 0, 4, 0);
        vt[5] = mk(0,0,0,0,    0,0,0,0,  0,0,0,1,0,0,1, 0, 0, 0);
        vt[6] = mk(0,0,0,0,    0,0,0,0,  0,0,0,0,0,0,0, 'h10, 0, 0);
        for (int j = 0; j < 12; j++) begin
            int  ph;
            logic w;
            ph = j % 3;
            w  = ((j / 3) % 2) == 1;
            vt[7+j] = mk(1,1,8,'h55, 1,0,8,0,
                         ph == 0 && !w, ph == 0 && w, ph == 2 && !w, ph == 2 && w,
                         ph == 1 && !w, ph == 1 && w, ph != 0,
                         (j >= 6) ? 32'h55 : 32'h10, 8, 'h55);
        end
        vt[19] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 'h55, 0, 0);

        // Reset state, with a request held to show gnt stays low in reset.
        @(negedge clk);
        chk("rst_gnt0", 64'(gnt0), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done0 | done1), 0);
        chk("rst_en", 64'(mem_wr_en | mem_rd_en), 0);
        chk("rst_maddr", 64'(mem_addr), 0);
        chk("rst_mwdata", 64'(mem_wdata), 0);
        chk("rst_rdata", 64'({rdata0, rdata1}), 0);
        req0 = 1'b0;
        next_cycle();
        mem_clr = 1'b0;
        rst = 1'b1;

        for (int k = 0; k < 20; k++) begin
            req0 = vt[k].r0; we0 = vt[k].w0; addr0 = vt[k].a0; wdata0 = vt[k].d0;
            req1 = vt[k].r1; we1 = vt[k].w1; addr1 = vt[k].a1; wdata1 = vt[k].d1;
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", k),  64'(gnt0), 64'(vt[k].g0));
            chk($sformatf("v%0d_gnt1", k),  64'(gnt1), 64'(vt[k].g1));
            chk($sformatf("v%0d_done0", k), 64'(done0), 64'(vt[k].dn0));
            chk($sformatf("v%0d_done1", k), 64'(done1), 64'(vt[k].dn1));
            chk($sformatf("v%0d_wr", k),    64'(mem_wr_en), 64'(vt[k].wr));
            chk($sformatf("v%0d_rd", k),    64'(mem_rd_en), 64'(vt[k].rd));
            chk($sformatf("v%0d_busy", k),  64'(busy), 64'(vt[k].bz));
            chk($sformatf("v%0d_rdata1", k), 64'(rdata1), 64'(vt[k].rd1));
            chk($sformatf("v%0d_rdata0", k), 64'(rdata0), 0);
            if (vt[k].wr || vt[k].rd)
                chk($sformatf("v%0d_maddr", k), 64'(mem_addr), 64'(vt[k].ea));
            if (vt[k].wr)
                chk($sformatf("v%0d_mwdata", k), 64'(mem_wdata), 64'(vt[k].ed));
            inv_chk();
            next_cycle();
        end

        // Withdrawn request: port 0 pulses req only while port 1 is busy.
        req1 = 1'b1; we1 = 1'b0; addr1 = 4;
        @(negedge clk); chk("wd_gnt1", 64'(gnt1), 1); inv_chk(); next_cycle();
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 'hC; wdata0 = 'hEE;
        @(negedge clk);
        chk("wd_gnt0_access", 64'(gnt0), 0);
        chk("wd_rd", 64'(mem_rd_en), 1);
        inv_chk(); next_cycle();
        req0 = 1'b0;
        @(negedge clk); chk("wd_done1", 64'(done1), 1); chk("wd_done0", 64'(done0), 0); inv_chk(); next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wd_idle_gnt0", 64'(gnt0), 0);
            chk("wd_idle_en", 64'(mem_wr_en | mem_rd_en), 0);
            chk("wd_idle_done0", 64'(done0), 0);
            chk("wd_idle_busy", 64'(busy), 0);
            inv_chk(); next_cycle();
        end
        chk("wd_rdata1", 64'(rdata1), 'h10);

        // Reset during the ACCESS cycle of a port-0 load.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8;
        @(negedge clk); chk("rm_gnt0", 64'(gnt0), 1); next_cycle();
        req0 = 1'b0;
        @(negedge clk); chk("rm_rd_before", 64'(mem_rd_en), 1);
        #2 rst = 1'b0;
        #1;
        chk("rm_rd_after", 64'(mem_rd_en), 0);
        chk("rm_busy", 64'(busy), 0);
        chk("rm_done", 64'(done0 | done1), 0);
        chk("rm_rdata0", 64'(rdata0), 0);
        chk("rm_maddr", 64'(mem_addr), 0);
        next_cycle();
        @(negedge clk);
        chk("rm_done_later", 64'(done0 | done1), 0);
        chk("rm_busy_later", 64'(busy), 0);
        #1 rst = 1'b1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 2; wdata1 = 7;
        #1 chk("rm_first_gnt1", 64'(gnt1), 1);
        next_cycle();
        req1 = 1'b0;
        @(negedge clk);
        chk("rm_wr", 64'(mem_wr_en), 1);
        chk("rm_waddr", 64'(mem_addr), 2);
        chk("rm_wdata", 64'(mem_wdata), 7);
        next_cycle();
        @(negedge clk); chk("rm_done1", 64'(done1), 1); next_cycle();

        // Random traffic from a clean reset, checked against the model.
        rst = 1'b0; mem_clr = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        next_cycle();
        mem_clr = 1'b0; rst = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        ref_rd[0] = '0; ref_rd[1] = '0;
        ref_last = 1'b1; ref_ma = '0; ref_mwd = '0;
        cport = 1'b0; cwe = 1'b0; caddr = '0; cwd = '0;
        cyc = 0; gcyc = -10;
        pend0 = 1'b0; pend1 = 1'b0; sg0 = 1'b0; sg1 = 1'b0;

        for (int i = 0; i < 600; i++) begin
            if (sg0) pend0 = 1'b0;
            else if (pend0 && $urandom_range(15) == 0) pend0 = 1'b0;
            else if (!pend0 && $urandom_range(2) == 0) begin
                pend0 = 1'b1; we0 = 1'($urandom_range(1));
                addr0 = $urandom_range(15); wdata0 = $urandom;
            end
            if (sg1) pend1 = 1'b0;
            else if (pend1 && $urandom_range(15) == 0) pend1 = 1'b0;
            else if (!pend1 && $urandom_range(2) == 0) begin
                pend1 = 1'b1; we1 = 1'($urandom_range(1));
                addr1 = $urandom_range(15); wdata1 = $urandom;
            end
            req0 = pend0; req1 = pend1;

            @(negedge clk);
            off = cyc - gcyc;
            chk("rnd_rdata0", 64'(rdata0), 64'(ref_rd[0]));
            chk("rnd_rdata1", 64'(rdata1), 64'(ref_rd[1]));
            chk("rnd_maddr", 64'(mem_addr), 64'(ref_ma));
            chk("rnd_mwdata", 64'(mem_wdata), 64'(ref_mwd));
            if (off >= 3 && (req0 || req1)) begin
                p     = (req0 && req1) ? !ref_last : req1;
                gcyc  = cyc; off = 0; ref_last = p; cport = p;
                cwe   = p ? we1 : we0;
                caddr = p ? addr1 : addr0;
                cwd   = p ? wdata1 : wdata0;
                ref_ma = caddr; ref_mwd = cwd;
            end
            chk("rnd_gnt0", 64'(gnt0), 64'(off == 0 && !cport));
            chk("rnd_gnt1", 64'(gnt1), 64'(off == 0 && cport));
            chk("rnd_busy", 64'(busy), 64'(off == 1 || off == 2));
            chk("rnd_wr", 64'(mem_wr_en), 64'(off == 1 && cwe));
            chk("rnd_rd", 64'(mem_rd_en), 64'(off == 1 && !cwe));
            chk("rnd_done0", 64'(done0), 64'(off == 2 && !cport));
            chk("rnd_done1", 64'(done1), 64'(off == 2 && cport));
            inv_chk();
            if (off == 1 && cwe) ref_mem[caddr[3:0]] = cwd;
            if (off == 2 && !cwe) ref_rd[cport] = ref_mem[caddr[3:0]];
            sg0 = gnt0; sg1 = gnt1;
            cyc++;
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of the requester and memory address buses.
REQ-002 Parameter DATA_W, default 32, width of the write-data and read-data buses.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-005 req0 / req1  in  1  access request from port 0 / port 1.
REQ-006 we0 / we1  in  1  1 = store, 0 = load, for port 0 / port 1.
REQ-007 addr0 / addr1  in  ADDR_W  access address for port 0 / port 1.
REQ-008 wdata0 / wdata1  in  DATA_W  store data for port 0 / port 1.
REQ-009 gnt0 / gnt1  out  1  one-cycle pulse: the request on this port has been accepted and latched.
REQ-010 done0 / done1  out  1  one-cycle pulse: the access on this port has completed.
REQ-011 rdata0 / rdata1  out  DATA_W  load result; valid in the done cycle of a load, held until the next load completes on the same port.
REQ-012 busy  out  1  1 whenever the state is not IDLE.
REQ-013 mem_addr  out  ADDR_W  address to data_mem in_addr.
REQ-014 mem_wdata  out  DATA_W  write data to data_mem in_data.
REQ-015 mem_wr_en / mem_rd_en  out  1  to data_mem wr_en / rd_en.
REQ-016 mem_rdata  in  DATA_W  from data_mem out_data.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-018 IDLE SHALL sample req0/req1 each cycle:
  - if neither is asserted, stay in IDLE;
  - otherwise select a winner, latch its we/addr/wdata and port id, pulse its gnt, and go to ACCESS.
REQ-019 Arbitration SHALL be round-robin:
  - a single requester wins outright;
  - if both are asserted, the port not granted last wins;
  - the last-granted register updates in the gnt cycle.
REQ-020 ACCESS SHALL last one cycle and drive:
  - mem_addr and mem_wdata from the latched values;
  - mem_wr_en = latched we, mem_rd_en = NOT latched we;
  - then go to RESP.
REQ-021 RESP SHALL last one cycle:
  - pulse done of the latched port;
  - for a load, capture mem_rdata into that port's rdata register at the end of the RESP cycle, so rdata is valid in the cycle after done;
  - then go to IDLE.
REQ-022 Correction to REQ-011: rdata SHALL be valid from the cycle after done until the next load completes on that port.
REQ-023 Latency:
  - request seen in IDLE at edge N gives gnt in cycle N, ACCESS in N+1, done in N+2 and rdata in N+3;
  - minimum spacing between accesses is 3 cycles.
REQ-024 mem_wr_en and mem_rd_en SHALL be 0 in every cycle outside ACCESS and SHALL never both be 1.
REQ-025 mem_addr and mem_wdata SHALL hold the last latched values outside ACCESS.
REQ-026 Requests SHALL be sampled only in IDLE. A requester holds req until it sees gnt; inputs after gnt are don't-care.
REQ-027 A req deasserted before gnt SHALL produce no memory access and no done.
REQ-028 A request arriving during ACCESS/RESP SHALL wait and be arbitrated on return to IDLE.
REQ-029 The port granted last SHALL lose the next simultaneous contention, so neither port starves.
REQ-030 gnt0 and gnt1 SHALL never be asserted together; likewise done0 and done1.

Reset
REQ-031 On rst = 0, asynchronously:
  - state = IDLE;
  - all gnt/done/busy/mem_wr_en/mem_rd_en outputs = 0;
  - mem_addr, mem_wdata, rdata0, rdata1 = 0;
  - last-granted = port 1, so port 0 wins the first contention.
REQ-032 Reset asserted during ACCESS or RESP SHALL abort the access with no done pulse and no rdata update. A write aborted in ACCESS may already have been committed by the memory.
REQ-033 After rst returns to 1, the first request SHALL be sampled at the first rising edge.

Verification
REQ-034 Single store: req0=1, we0=1, addr0=0x4, wdata0=0x10
  -> gnt0 at cycle N, mem_wr_en=1 with mem_addr=0x4/mem_wdata=0x10 at N+1, done0 at N+2.
REQ-035 Load-back: req1=1, we1=0, addr1=0x4 after REQ-034
  -> mem_rd_en=1 at N+1, done1 at N+2, rdata1=0x10 from N+3.
REQ-036 Contention: first contention after reset with both req0/req1 held
  -> gnt sequence 0,1,0,1 spaced 3 cycles apart; gnt0 and gnt1 never high together.
REQ-037 Withdrawn request: req0 pulsed during ACCESS of a port-1 access and dropped before IDLE
  -> no gnt0, no memory enable, no done0.
REQ-038 Reset mid-access: rst=0 in the ACCESS cycle of a load
  -> mem_rd_en=0 immediately, busy=0, no done pulse, rdata unchanged (0); after release, the next request is granted normally.
REQ-039 Continuous check on every cycle:
  - mem_wr_en and mem_rd_en never both 1;
  - neither is 1 outside ACCESS.
